// File: rtl/ysyx_idu_pipe.sv
// RV32I decode stage with one registered output slot, valid/ready handshake, flush and a drain counter.
// Optional RV32M decode is enabled by defining YSYX_IDU_RVM_EN.
`timescale 1ns/1ps
module ysyx_idu_pipe #(
  parameter int XLEN   = 32,
  parameter int NR_REG = 32,
  parameter int CNT_W  = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_inst,
  input  logic [XLEN-1:0]  in_pc,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_pc,
  output logic [4:0]       out_rs1,
  output logic [4:0]       out_rs2,
  output logic [4:0]       out_rd,
  output logic [XLEN-1:0]  out_imm,
  output logic             out_rf_wr_en,
  output logic [1:0]       out_rf_wr_sel,
  output logic             out_do_jump,
  output logic [2:0]       out_br_type,
  output logic             out_alu_a_sel,
  output logic             out_alu_b_sel,
  output logic [3:0]       out_alu_ctrl,
  output logic [2:0]       out_dm_rd_sel,
  output logic [1:0]       out_dm_wr_sel,
  output logic             out_md_en,
  output logic [2:0]       out_md_op,
  output logic             out_illegal,
  output logic             out_ebreak,
  output logic             out_ecall,
  output logic [CNT_W-1:0] dec_cnt
);

  if (XLEN != 32) begin : g_bad_xlen
    $error("ysyx_idu_pipe: XLEN must be 32");
  end

  localparam logic [6:0] OP_LUI = 7'h37, OP_AUIPC = 7'h17, OP_JAL = 7'h6F, OP_JALR = 7'h67;
  localparam logic [6:0] OP_BR  = 7'h63, OP_LD    = 7'h03, OP_ST  = 7'h23, OP_IMM  = 7'h13;
  localparam logic [6:0] OP_REG = 7'h33, OP_FENCE = 7'h0F, OP_SYS = 7'h73;

  localparam logic [1:0] WR_PC4 = 2'b01, WR_ALU = 2'b10, WR_MEM = 2'b11;
  localparam logic [3:0] ALU_ADD = 4'b0000, ALU_SUB = 4'b1000, ALU_SLL = 4'b0001, ALU_SLT = 4'b0010;
  localparam logic [3:0] ALU_SLTU = 4'b0011, ALU_XOR = 4'b0100, ALU_SRL = 4'b0101, ALU_SRA = 4'b1101;
  localparam logic [3:0] ALU_OR = 4'b0110, ALU_AND = 4'b0111, ALU_PASSB = 4'b1110;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic [XLEN-1:0] imm;
    logic            rf_wr_en;
    logic [1:0]      rf_wr_sel;
    logic            do_jump;
    logic [2:0]      br_type;
    logic            alu_a_sel;
    logic            alu_b_sel;
    logic [3:0]      alu_ctrl;
    logic [2:0]      dm_rd_sel;
    logic [1:0]      dm_wr_sel;
    logic            md_en;
    logic [2:0]      md_op;
    logic            illegal;
    logic            ebreak;
    logic            ecall;
  } bundle_t;

  function automatic logic [3:0] alu_of(input logic [2:0] f3, input logic alt);
    logic [3:0] r;
    case (f3)
      3'd0:    r = alt ? ALU_SUB : ALU_ADD;
      3'd1:    r = ALU_SLL;
      3'd2:    r = ALU_SLT;
      3'd3:    r = ALU_SLTU;
      3'd4:    r = ALU_XOR;
      3'd5:    r = alt ? ALU_SRA : ALU_SRL;
      3'd6:    r = ALU_OR;
      default: r = ALU_AND;
    endcase
    return r;
  endfunction

  function automatic logic bad_idx(input logic [4:0] r);
    return int'({27'b0, r}) >= NR_REG;
  endfunction

  logic [6:0]      opc, f7;
  logic [2:0]      f3;
  logic [4:0]      rd_f, rs1_f, rs2_f;
  logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j;

  assign opc   = in_inst[6:0];
  assign f3    = in_inst[14:12];
  assign f7    = in_inst[31:25];
  assign rd_f  = in_inst[11:7];
  assign rs1_f = in_inst[19:15];
  assign rs2_f = in_inst[24:20];
  assign imm_i = {{(XLEN-12){in_inst[31]}}, in_inst[31:20]};
  assign imm_s = {{(XLEN-12){in_inst[31]}}, in_inst[31:25], in_inst[11:7]};
  assign imm_b = {{(XLEN-12){in_inst[31]}}, in_inst[7], in_inst[30:25], in_inst[11:8], 1'b0};
  assign imm_j = {{(XLEN-20){in_inst[31]}}, in_inst[19:12], in_inst[20], in_inst[30:21], 1'b0};
  assign imm_u = XLEN'($signed({in_inst[31:12], 12'b0}));

  bundle_t dec;
  logic    ill, use_rd, use_rs1, use_rs2;

  always_comb begin
    dec     = '0;
    dec.pc  = in_pc;
    ill     = 1'b0;
    use_rd  = 1'b0;
    use_rs1 = 1'b0;
    use_rs2 = 1'b0;
    case (opc)
      OP_LUI: begin
        use_rd = 1'b1; dec.imm = imm_u; dec.rf_wr_en = 1'b1; dec.rf_wr_sel = WR_ALU;
        dec.alu_b_sel = 1'b1; dec.alu_ctrl = ALU_PASSB;
      end
      OP_AUIPC: begin
        use_rd = 1'b1; dec.imm = imm_u; dec.rf_wr_en = 1'b1; dec.rf_wr_sel = WR_ALU;
        dec.alu_b_sel = 1'b1;
      end
      OP_JAL: begin
        use_rd = 1'b1; dec.imm = imm_j; dec.rf_wr_en = 1'b1; dec.rf_wr_sel = WR_PC4;
        dec.do_jump = 1'b1; dec.alu_b_sel = 1'b1;
      end
      OP_JALR: begin
        use_rd = 1'b1; use_rs1 = 1'b1; dec.imm = imm_i; dec.rf_wr_en = 1'b1; dec.rf_wr_sel = WR_PC4;
        dec.do_jump = 1'b1; dec.alu_a_sel = 1'b1; dec.alu_b_sel = 1'b1;
        ill = (f3 != 3'd0);
      end
      OP_BR: begin
        use_rs1 = 1'b1; use_rs2 = 1'b1; dec.imm = imm_b; dec.alu_b_sel = 1'b1;
        case (f3)
          3'd0:       dec.br_type = 3'b010;
          3'd1:       dec.br_type = 3'b011;
          3'd2, 3'd3: ill = 1'b1;
          default:    dec.br_type = f3;
        endcase
      end
      OP_LD: begin
        use_rd = 1'b1; use_rs1 = 1'b1; dec.imm = imm_i; dec.rf_wr_en = 1'b1; dec.rf_wr_sel = WR_MEM;
        dec.alu_a_sel = 1'b1; dec.alu_b_sel = 1'b1;
        case (f3)
          3'd0:    dec.dm_rd_sel = 3'b001;
          3'd1:    dec.dm_rd_sel = 3'b011;
          3'd2:    dec.dm_rd_sel = 3'b101;
          3'd4:    dec.dm_rd_sel = 3'b010;
          3'd5:    dec.dm_rd_sel = 3'b100;
          default: ill = 1'b1;
        endcase
      end
      OP_ST: begin
        use_rs1 = 1'b1; use_rs2 = 1'b1; dec.imm = imm_s; dec.alu_a_sel = 1'b1; dec.alu_b_sel = 1'b1;
        case (f3)
          3'd0:    dec.dm_wr_sel = 2'b01;
          3'd1:    dec.dm_wr_sel = 2'b10;
          3'd2:    dec.dm_wr_sel = 2'b11;
          default: ill = 1'b1;
        endcase
      end
      OP_IMM: begin
        use_rd = 1'b1; use_rs1 = 1'b1; dec.imm = imm_i; dec.rf_wr_en = 1'b1; dec.rf_wr_sel = WR_ALU;
        dec.alu_a_sel = 1'b1; dec.alu_b_sel = 1'b1;
        dec.alu_ctrl = alu_of(f3, (f3 == 3'd5) && in_inst[30]);
        // shift-immediate forms reserve the funct7 field; only srai may set bit 30
        if (f3 == 3'd1)      ill = (f7 != 7'h00);
        else if (f3 == 3'd5) ill = (f7 != 7'h00) && (f7 != 7'h20);
      end
      OP_REG: begin
        use_rd = 1'b1; use_rs1 = 1'b1; use_rs2 = 1'b1; dec.rf_wr_en = 1'b1; dec.rf_wr_sel = WR_ALU;
        dec.alu_a_sel = 1'b1;
        if (f7 == 7'h00) begin
          dec.alu_ctrl = alu_of(f3, 1'b0);
        end else if (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5)) begin
          dec.alu_ctrl = alu_of(f3, 1'b1);
        end else if (f7 == 7'h01) begin
`ifdef YSYX_IDU_RVM_EN
          dec.md_en = 1'b1; dec.md_op = f3; dec.alu_ctrl = ALU_ADD;
`else
          ill = 1'b1;
`endif
        end else begin
          ill = 1'b1;
        end
      end
      OP_FENCE: ill = (f3 != 3'd0);
      OP_SYS: begin
        dec.ecall  = (in_inst == 32'h0000_0073);
        dec.ebreak = (in_inst == 32'h0010_0073);
        ill        = !(dec.ecall || dec.ebreak);
      end
      default: ill = 1'b1;
    endcase
    if (use_rd)  dec.rd  = rd_f;
    if (use_rs1) dec.rs1 = rs1_f;
    if (use_rs2) dec.rs2 = rs2_f;
    if ((use_rd && bad_idx(rd_f)) || (use_rs1 && bad_idx(rs1_f)) || (use_rs2 && bad_idx(rs2_f)))
      ill = 1'b1;
    // an illegal bundle carries only its pc and the flag, so nothing downstream has side effects
    if (ill) begin
      dec         = '0;
      dec.pc      = in_pc;
      dec.illegal = 1'b1;
    end
  end

  bundle_t          bnd_q, bnd_d;
  logic             out_valid_q, out_valid_d;
  logic [CNT_W-1:0] dec_cnt_q, dec_cnt_d;
  logic             accept, drain;

  assign in_ready = !out_valid_q || out_ready;
  assign accept   = in_valid && in_ready && !flush;
  assign drain    = out_valid_q && out_ready;

  always_comb begin
    bnd_d       = bnd_q;
    out_valid_d = out_valid_q;
    dec_cnt_d   = dec_cnt_q;
    if (drain) begin
      dec_cnt_d   = dec_cnt_q + CNT_W'(1);
      out_valid_d = 1'b0;
    end
    if (flush) begin
      out_valid_d = 1'b0;
    end else if (accept) begin
      out_valid_d = 1'b1;
      bnd_d       = dec;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bnd_q       <= '0;
      out_valid_q <= 1'b0;
      dec_cnt_q   <= '0;
    end else begin
      bnd_q       <= bnd_d;
      out_valid_q <= out_valid_d;
      dec_cnt_q   <= dec_cnt_d;
    end
  end

  assign out_valid     = out_valid_q;
  assign dec_cnt       = dec_cnt_q;
  assign out_pc        = bnd_q.pc;
  assign out_rs1       = bnd_q.rs1;
  assign out_rs2       = bnd_q.rs2;
  assign out_rd        = bnd_q.rd;
  assign out_imm       = bnd_q.imm;
  assign out_rf_wr_en  = bnd_q.rf_wr_en;
  assign out_rf_wr_sel = bnd_q.rf_wr_sel;
  assign out_do_jump   = bnd_q.do_jump;
  assign out_br_type   = bnd_q.br_type;
  assign out_alu_a_sel = bnd_q.alu_a_sel;
  assign out_alu_b_sel = bnd_q.alu_b_sel;
  assign out_alu_ctrl  = bnd_q.alu_ctrl;
  assign out_dm_rd_sel = bnd_q.dm_rd_sel;
  assign out_dm_wr_sel = bnd_q.dm_wr_sel;
  assign out_md_en     = bnd_q.md_en;
  assign out_md_op     = bnd_q.md_op;
  assign out_illegal   = bnd_q.illegal;
  assign out_ebreak    = bnd_q.ebreak;
  assign out_ecall     = bnd_q.ecall;

endmodule

// File: tb/tb_ysyx_idu_pipe.sv
// Bench for ysyx_idu_pipe: an RV32I (u_a) and an RV32E/4-bit-counter (u_e) instance share stimulus,
// checked against a mnemonic-level decode model and a handshake scoreboard.
`timescale 1ns/1ps
module tb_ysyx_idu_pipe;

`ifdef YSYX_IDU_RVM_EN
  localparam bit RVM = 1'b1;
`else
  localparam bit RVM = 1'b0;
`endif

  typedef struct packed {
    logic [31:0] pc;
    logic [4:0]  rs1, rs2, rd;
    logic [31:0] imm;
    logic        wr_en;
    logic [1:0]  wr_sel;
    logic        jump;
    logic [2:0]  br;
    logic        a_sel, b_sel;
    logic [3:0]  alu;
    logic [2:0]  rd_sel;
    logic [1:0]  dm_wr;
    logic        md_en;
    logic [2:0]  md_op;
    logic        ill, ebr, ecall;
  } bnd_t;

  logic clk = 1'b0, rst, flush, in_valid, out_ready;
  logic [31:0] in_inst, in_pc;
  always #5 clk = ~clk;

  logic        in_ready_a, out_valid_a, in_ready_e, out_valid_e;
  logic [31:0] dec_cnt_a;
  logic [3:0]  dec_cnt_e;
  logic [31:0] pc_a, imm_a, pc_e, imm_e;
  logic [4:0]  rs1_a, rs2_a, rd_a, rs1_e, rs2_e, rd_e;
  logic        wen_a, jmp_a, asel_a, bsel_a, mden_a, ill_a, ebr_a, ecl_a;
  logic        wen_e, jmp_e, asel_e, bsel_e, mden_e, ill_e, ebr_e, ecl_e;
  logic [1:0]  wsel_a, dmw_a, wsel_e, dmw_e;
  logic [2:0]  br_a, dmr_a, mdop_a, br_e, dmr_e, mdop_e;
  logic [3:0]  alu_a, alu_e;

  ysyx_idu_pipe u_a (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready_a),
    .in_inst(in_inst), .in_pc(in_pc), .out_valid(out_valid_a), .out_ready(out_ready),
    .out_pc(pc_a), .out_rs1(rs1_a), .out_rs2(rs2_a), .out_rd(rd_a), .out_imm(imm_a),
    .out_rf_wr_en(wen_a), .out_rf_wr_sel(wsel_a), .out_do_jump(jmp_a), .out_br_type(br_a),
    .out_alu_a_sel(asel_a), .out_alu_b_sel(bsel_a), .out_alu_ctrl(alu_a), .out_dm_rd_sel(dmr_a),
    .out_dm_wr_sel(dmw_a), .out_md_en(mden_a), .out_md_op(mdop_a), .out_illegal(ill_a),
    .out_ebreak(ebr_a), .out_ecall(ecl_a), .dec_cnt(dec_cnt_a));

  ysyx_idu_pipe #(.NR_REG(16), .CNT_W(4)) u_e (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready_e),
    .in_inst(in_inst), .in_pc(in_pc), .out_valid(out_valid_e), .out_ready(out_ready),
    .out_pc(pc_e), .out_rs1(rs1_e), .out_rs2(rs2_e), .out_rd(rd_e), .out_imm(imm_e),
    .out_rf_wr_en(wen_e), .out_rf_wr_sel(wsel_e), .out_do_jump(jmp_e), .out_br_type(br_e),
    .out_alu_a_sel(asel_e), .out_alu_b_sel(bsel_e), .out_alu_ctrl(alu_e), .out_dm_rd_sel(dmr_e),
    .out_dm_wr_sel(dmw_e), .out_md_en(mden_e), .out_md_op(mdop_e), .out_illegal(ill_e),
    .out_ebreak(ebr_e), .out_ecall(ecl_e), .dec_cnt(dec_cnt_e));

  bnd_t obs_a, obs_e;
  assign obs_a = {pc_a, rs1_a, rs2_a, rd_a, imm_a, wen_a, wsel_a, jmp_a, br_a, asel_a, bsel_a,
                  alu_a, dmr_a, dmw_a, mden_a, mdop_a, ill_a, ebr_a, ecl_a};
  assign obs_e = {pc_e, rs1_e, rs2_e, rd_e, imm_e, wen_e, wsel_e, jmp_e, br_e, asel_e, bsel_e,
                  alu_e, dmr_e, dmw_e, mden_e, mdop_e, ill_e, ebr_e, ecl_e};

  int   n_chk = 0, n_fail = 0;
  bnd_t m_a, m_e;
  logic m_valid = 1'b0;
  int unsigned m_cnt = 0;

  // Reference decode from the ISA tables; immediates assembled arithmetically.
  function automatic bnd_t ref_dec(input logic [31:0] i, input logic [31:0] pc, input int nreg);
    bnd_t b;
    logic [6:0] op, f7;
    logic [2:0] f3;
    logic ok, u_rd, u_rs1, u_rs2;
    logic [31:0] ii, is_, ib, ij, iu;
    b = '0; op = i[6:0]; f3 = i[14:12]; f7 = i[31:25];
    ok = 1'b1; u_rd = 1'b0; u_rs1 = 1'b0; u_rs2 = 1'b0;
    ii  = $signed(i) >>> 20;
    is_ = (ii & ~32'h1f) | 32'(i[11:7]);
    ib  = (i[31] ? 32'hFFFF_F000 : 32'h0) + 32'(i[7]) * 2048 + 32'(i[30:25]) * 32 + 32'(i[11:8]) * 2;
    ij  = (i[31] ? 32'hFFF0_0000 : 32'h0) + 32'(i[19:12]) * 4096 + 32'(i[20]) * 2048 + 32'(i[30:21]) * 2;
    iu  = i & 32'hFFFF_F000;
    b.pc = pc;
    case (op)
      7'h37: begin u_rd = 1; b.imm = iu; b.wr_en = 1; b.wr_sel = 2; b.b_sel = 1; b.alu = 4'hE; end
      7'h17: begin u_rd = 1; b.imm = iu; b.wr_en = 1; b.wr_sel = 2; b.b_sel = 1; end
      7'h6F: begin u_rd = 1; b.imm = ij; b.wr_en = 1; b.wr_sel = 1; b.jump = 1; b.b_sel = 1; end
      7'h67: begin
        ok = (f3 == 0); u_rd = 1; u_rs1 = 1; b.imm = ii; b.wr_en = 1; b.wr_sel = 1; b.jump = 1;
        b.a_sel = 1; b.b_sel = 1;
      end
      7'h63: begin
        ok = (f3 != 2 && f3 != 3); u_rs1 = 1; u_rs2 = 1; b.imm = ib; b.b_sel = 1;
        b.br = f3[2] ? f3 : {2'b01, f3[0]};
      end
      7'h03: begin
        u_rd = 1; u_rs1 = 1; b.imm = ii; b.wr_en = 1; b.wr_sel = 3; b.a_sel = 1; b.b_sel = 1;
        case (f3)
          0: b.rd_sel = 1; 1: b.rd_sel = 3; 2: b.rd_sel = 5; 4: b.rd_sel = 2; 5: b.rd_sel = 4;
          default: ok = 0;
        endcase
      end
      7'h23: begin
        ok = (f3 < 3); u_rs1 = 1; u_rs2 = 1; b.imm = is_; b.dm_wr = 2'(f3 + 1); b.a_sel = 1; b.b_sel = 1;
      end
      7'h13: begin
        u_rd = 1; u_rs1 = 1; b.imm = ii; b.wr_en = 1; b.wr_sel = 2; b.a_sel = 1; b.b_sel = 1;
        b.alu = {f3 == 5 && f7[5], f3};
        if (f3 == 1) ok = (f7 == 0);
        if (f3 == 5) ok = (f7 == 0 || f7 == 7'h20);
      end
      7'h33: begin
        u_rd = 1; u_rs1 = 1; u_rs2 = 1; b.wr_en = 1; b.wr_sel = 2; b.a_sel = 1;
        if (f7 == 1) begin ok = RVM; b.md_en = 1; b.md_op = f3; end
        else begin ok = (f7 == 0) || (f7 == 7'h20 && (f3 == 0 || f3 == 5)); b.alu = {f7[5], f3}; end
      end
      7'h0F: ok = (f3 == 0);
      7'h73: begin b.ecall = (i == 32'h73); b.ebr = (i == 32'h100073); ok = b.ecall || b.ebr; end
      default: ok = 0;
    endcase
    if (u_rd)  b.rd  = i[11:7];
    if (u_rs1) b.rs1 = i[19:15];
    if (u_rs2) b.rs2 = i[24:20];
    if ((u_rd && int'(i[11:7]) >= nreg) || (u_rs1 && int'(i[19:15]) >= nreg) ||
        (u_rs2 && int'(i[24:20]) >= nreg)) ok = 0;
    if (!ok) begin b = '0; b.pc = pc; b.ill = 1; end
    return b;
  endfunction

  function automatic logic [31:0] rand_inst();
    logic [31:0] r;
    logic [6:0] ops [11] = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33, 7'h0F, 7'h73};
    r = $urandom;
    case ($urandom_range(0, 9))
      0: return 32'h0000_0073;
      1: return 32'h0010_0073;
      2: return r;
      default: ;
    endcase
    r[6:0] = ops[$urandom_range(0, 10)];
    case ($urandom_range(0, 3))
      0: r[31:25] = 7'h00;
      1: r[31:25] = 7'h20;
      2: r[31:25] = 7'h01;
      default: ;
    endcase
    return r;
  endfunction

  // Advance one clock while tracking the expected handshake state.
  task automatic cycle();
    logic acc, drn;
    acc = in_valid && (!m_valid || out_ready) && !flush;
    drn = m_valid && out_ready;
    @(posedge clk);
    if (rst) begin
      m_valid = 0; m_a = '0; m_e = '0; m_cnt = 0;
    end else begin
      if (drn) m_cnt++;
      if (acc) begin
        m_a = ref_dec(in_inst, in_pc, 32); m_e = ref_dec(in_inst, in_pc, 16); m_valid = 1;
      end else if (drn || flush) m_valid = 0;
    end
    #1;
  endtask

  task automatic test_reset();
    rst = 1; flush = 0; in_valid = 1; out_ready = 1; in_inst = 32'hFFF3_0293; in_pc = 32'h8000_0000;
    repeat (2) begin
      cycle();
      n_chk++;
      if (out_valid_a !== 1'b0 || dec_cnt_a !== 32'd0 || obs_a !== '0 || out_valid_e !== 1'b0 ||
          dec_cnt_e !== 4'd0 || obs_e !== '0) begin
        n_fail++;
        $display("FAIL reset_state: valid=%b cnt=%0d bundle=%h, required valid=0 cnt=0 bundle=0",
                 out_valid_a, dec_cnt_a, obs_a);
      end
    end
    rst = 0; #1;
    n_chk++;
    if (in_ready_a !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b want 1", in_ready_a); end
    cycle();
    n_chk++;
    if (out_valid_a !== 1'b1 || obs_a !== m_a) begin
      n_fail++; $display("FAIL reset_release: valid=%b bundle=%h want valid=1 bundle=%h", out_valid_a, obs_a, m_a);
    end
  endtask

  task automatic test_addi();
    in_valid = 1; out_ready = 1; in_inst = 32'hFFF3_0293; in_pc = 32'h8000_0004;
    cycle();
    n_chk++;
    if (out_valid_a !== 1 || rd_a !== 5'd5 || rs1_a !== 5'd6 || imm_a !== 32'hFFFF_FFFF ||
        alu_a !== 4'b0000 || wsel_a !== 2'b10 || wen_a !== 1'b1 || pc_a !== 32'h8000_0004) begin
      n_fail++;
      $display("FAIL addi_fields: v=%b rd=%0d rs1=%0d imm=%h alu=%b wsel=%b wen=%b, want 1/5/6/ffffffff/0000/10/1",
               out_valid_a, rd_a, rs1_a, imm_a, alu_a, wsel_a, wen_a);
    end
    n_chk++;
    if (obs_a !== m_a) begin n_fail++; $display("FAIL addi_model: got %h want %h", obs_a, m_a); end
  endtask

  task automatic test_backpressure();
    bnd_t snap;
    int unsigned c0;
    snap = m_a; c0 = m_cnt;
    out_ready = 0; in_valid = 1; in_inst = 32'h00A0_0093; in_pc = 32'h8000_0008;
    repeat (3) begin
      #1;
      n_chk++;
      if (in_ready_a !== 1'b0) begin n_fail++; $display("FAIL hold_in_ready: got %b want 0", in_ready_a); end
      cycle();
      n_chk++;
      if (out_valid_a !== 1'b1 || obs_a !== snap || dec_cnt_a !== c0) begin
        n_fail++; $display("FAIL hold_stable: v=%b bundle=%h cnt=%0d want 1 %h %0d", out_valid_a, obs_a, dec_cnt_a, snap, c0);
      end
    end
    out_ready = 1; #1;
    n_chk++;
    if (in_ready_a !== 1'b1) begin n_fail++; $display("FAIL drain_in_ready: got %b want 1", in_ready_a); end
    cycle();
    n_chk++;
    if (dec_cnt_a !== c0 + 1 || out_valid_a !== 1'b1 || obs_a !== m_a || rd_a !== 5'd1 || imm_a !== 32'd10) begin
      n_fail++; $display("FAIL drain_replace: cnt=%0d rd=%0d imm=%h want cnt=%0d rd=1 imm=a", dec_cnt_a, rd_a, imm_a, c0 + 1);
    end
    in_valid = 0;
    cycle();
    n_chk++;
    if (dec_cnt_a !== c0 + 2 || out_valid_a !== 1'b0) begin
      n_fail++; $display("FAIL drain_empty: cnt=%0d v=%b want cnt=%0d v=0", dec_cnt_a, out_valid_a, c0 + 2);
    end
  endtask

  task automatic test_flush_branch();
    int unsigned c0;
    in_valid = 1; out_ready = 1; in_inst = 32'hFE20_DCE3; in_pc = 32'h8000_0100;
    cycle();
    n_chk++;
    if (out_valid_a !== 1 || br_a !== 3'b101 || imm_a !== 32'hFFFF_FFF8 || rs1_a !== 5'd1 || rs2_a !== 5'd2 ||
        wen_a !== 1'b0) begin
      n_fail++; $display("FAIL bge_fields: v=%b br=%b imm=%h rs1=%0d rs2=%0d want 1 101 fffffff8 1 2", out_valid_a, br_a, imm_a, rs1_a, rs2_a);
    end
    c0 = m_cnt;
    flush = 1; in_inst = 32'hFFF3_0293; in_pc = 32'h8000_0104; #1;
    n_chk++;
    if (in_ready_a !== 1'b1) begin n_fail++; $display("FAIL flush_in_ready: got %b want 1", in_ready_a); end
    cycle();
    n_chk++;
    if (out_valid_a !== 1'b0 || dec_cnt_a !== c0 + 1) begin
      n_fail++; $display("FAIL flush_drop: v=%b cnt=%0d want 0 %0d", out_valid_a, dec_cnt_a, c0 + 1);
    end
    flush = 0; in_valid = 0;
    repeat (2) begin
      cycle();
      n_chk++;
      if (out_valid_a !== 1'b0) begin n_fail++; $display("FAIL flush_ghost: v=%b want 0", out_valid_a); end
    end
  endtask

  task automatic test_mul();
    in_valid = 1; out_ready = 1; in_inst = 32'h02B5_0533; in_pc = 32'h8000_0200;
    cycle();
    in_valid = 0;
    n_chk++;
`ifdef YSYX_IDU_RVM_EN
    if ({mden_a, mdop_a, wen_a, wsel_a, alu_a, ill_a} !== {1'b1, 3'b000, 1'b1, 2'b10, 4'b0000, 1'b0}) begin
      n_fail++; $display("FAIL mul_rvm: md_en=%b md_op=%b wen=%b ill=%b want 1 000 1 0", mden_a, mdop_a, wen_a, ill_a);
    end
`else
    if ({ill_a, wen_a, mden_a, mdop_a} !== {1'b1, 1'b0, 1'b0, 3'b000}) begin
      n_fail++; $display("FAIL mul_off: ill=%b wen=%b md_en=%b md_op=%b want 1 0 0 000", ill_a, wen_a, mden_a, mdop_a);
    end
`endif
    n_chk++;
    if (obs_a !== m_a) begin n_fail++; $display("FAIL mul_model: got %h want %h", obs_a, m_a); end
  endtask

  task automatic test_rv32e_system();
    logic [31:0] seq [3] = '{32'h0020_88B3, 32'h0010_0073, 32'h0000_0073};
    logic [2:0]  want_e [3] = '{3'b100, 3'b010, 3'b001};
    logic [2:0]  want_a [3] = '{3'b000, 3'b010, 3'b001};
    out_ready = 1;
    for (int k = 0; k < 3; k++) begin
      in_valid = 1; in_inst = seq[k]; in_pc = 32'h8000_0300 + 32'(k * 4);
      cycle();
      n_chk++;
      if ({ill_e, ebr_e, ecl_e} !== want_e[k] || {ill_a, ebr_a, ecl_a} !== want_a[k] || wen_a !== (k == 0) ||
          wen_e !== 1'b0 || out_valid_e !== 1'b1) begin
        n_fail++;
        $display("FAIL sys_rv32e[%0d]: e{ill,ebr,ecl}=%b a=%b wen_a=%b wen_e=%b want e=%b a=%b", k,
                 {ill_e, ebr_e, ecl_e}, {ill_a, ebr_a, ecl_a}, wen_a, wen_e, want_e[k], want_a[k]);
      end
    end
    in_valid = 0;
    cycle();
  endtask

  task automatic test_back_to_back();
    in_valid = 1; out_ready = 1;
    for (int k = 0; k < 20; k++) begin
      in_inst = rand_inst(); in_pc = $urandom & ~32'h3;
      cycle();
      n_chk++;
      if (out_valid_a !== 1'b1 || dec_cnt_a !== m_cnt || dec_cnt_e !== 4'(m_cnt) || obs_a !== m_a || obs_e !== m_e) begin
        n_fail++;
        $display("FAIL b2b[%0d]: v=%b cnt=%0d/%0d bundle=%h want v=1 cnt=%0d/%0d bundle=%h", k, out_valid_a,
                 dec_cnt_a, dec_cnt_e, obs_a, m_cnt, 4'(m_cnt), m_a);
      end
    end
    in_valid = 0;
  endtask

  task automatic test_random();
    for (int k = 0; k < 800; k++) begin
      in_valid  = ($urandom_range(0, 9) < 7);
      out_ready = ($urandom_range(0, 9) < 7);
      flush     = ($urandom_range(0, 11) == 0);
      rst       = ($urandom_range(0, 99) == 0);
      in_inst   = rand_inst();
      in_pc     = $urandom & ~32'h3;
      #1;
      n_chk++;
      if (in_ready_a !== (!m_valid || out_ready) || in_ready_e !== in_ready_a) begin
        n_fail++; $display("FAIL rnd_in_ready[%0d]: got %b/%b want %b", k, in_ready_a, in_ready_e, !m_valid || out_ready);
      end
      cycle();
      n_chk++;
      if (out_valid_a !== m_valid || out_valid_e !== m_valid || dec_cnt_a !== m_cnt || dec_cnt_e !== 4'(m_cnt) ||
          (m_valid && (obs_a !== m_a || obs_e !== m_e))) begin
        n_fail++;
        $display("FAIL rnd_state[%0d]: v=%b cnt=%0d/%0d a=%h e=%h want v=%b cnt=%0d a=%h e=%h", k, out_valid_a,
                 dec_cnt_a, dec_cnt_e, obs_a, obs_e, m_valid, m_cnt, m_a, m_e);
      end
    end
    rst = 0; flush = 0; in_valid = 0;
  endtask

  initial begin
    test_reset();
    test_addi();
    test_backpressure();
    test_flush_branch();
    test_mul();
    test_rv32e_system();
    test_back_to_back();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
